uart_tx_fifo: RTL

- UART transmitter with a small transmit FIFO: 8 data bits, 1 start bit, 1 stop bit, LSB first; no parity unless the optional feature is enabled.
- CPU/MMIO side pushes bytes through a strobe plus ready handshake; the FIFO decouples bursts from line rate.
- Line idles high. It is the transmit counterpart of the existing UART receive path and uses the same CLKS_PER_BIT convention: CLKS_PER_BIT = clock freq / baud.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small circular FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               i_Clock,
  input  logic               reset,
  input  logic               i_Tx_DV,
  input  logic [7:0]         i_Tx_Byte,
  output logic               o_Tx_Ready,
  output logic [FIFO_AW:0]   o_Fifo_Count,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    PARITY  = 3'd5
  } t_state;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } t_state;
`endif

  t_state               r_State;
  t_state               w_State_Next;

  logic [7:0]           r_Mem [DEPTH];
  logic [FIFO_AW-1:0]   r_Wr_Ptr;
  logic [FIFO_AW-1:0]   r_Rd_Ptr;
  logic [FIFO_AW:0]     r_Count;

  logic [CNT_W-1:0]     r_Clk_Count;
  logic [2:0]           r_Bit_Index;
  logic [7:0]           r_Shift;

  logic                 r_Tx_Serial;
  logic                 r_Tx_Active;
  logic                 r_Tx_Done;

  logic                 w_Ready;
  logic                 w_Push;
  logic                 w_Pop;
  logic                 w_Bit_Done;
  logic                 w_Serial;
  logic                 w_Active;
  logic                 w_Done;

  // Ready comes from the registered count only, so a full FIFO rejects even during a pop.
  assign w_Ready    = (r_Count < (FIFO_AW + 1)'(DEPTH));
  assign w_Push     = i_Tx_DV && w_Ready;
  assign w_Pop      = (r_State == IDLE) && (r_Count != '0);
  assign w_Bit_Done = (r_Clk_Count == CNT_W'(CLKS_PER_BIT - 1));

  // FIFO storage: no reset needed, validity is tracked by the pointers and count.
  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + FIFO_AW'(1);
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + FIFO_AW'(1);
      unique case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + (FIFO_AW + 1)'(1);
        2'b01:   r_Count <= r_Count - (FIFO_AW + 1)'(1);
        default: r_Count <= r_Count;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (reset) r_State <= IDLE;
    else       r_State <= w_State_Next;
  end

  // Next-state logic
  always_comb begin
    w_State_Next = r_State;
    case (r_State)
      IDLE:    if (w_Pop) w_State_Next = START;
      START:   if (w_Bit_Done) w_State_Next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:    if (w_Bit_Done && (r_Bit_Index == 3'd7)) w_State_Next = PARITY;
      PARITY:  if (w_Bit_Done) w_State_Next = STOP;
`else
      DATA:    if (w_Bit_Done && (r_Bit_Index == 3'd7)) w_State_Next = STOP;
`endif
      STOP:    if (w_Bit_Done) w_State_Next = CLEANUP;
      CLEANUP: w_State_Next = IDLE;
      default: w_State_Next = IDLE;
    endcase
  end

  // Bit timing counter, bit index and shift register.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_Clk_Count <= '0;
      r_Bit_Index <= '0;
      r_Shift     <= '0;
    end else begin
      if ((r_State == IDLE) || (r_State == CLEANUP) || w_Bit_Done) begin
        r_Clk_Count <= '0;
      end else begin
        r_Clk_Count <= r_Clk_Count + CNT_W'(1);
      end
      if (r_State != DATA) begin
        r_Bit_Index <= '0;
      end else if (w_Bit_Done) begin
        r_Bit_Index <= r_Bit_Index + 3'd1;
      end
      if (w_Pop) begin
        r_Shift <= r_Mem[r_Rd_Ptr];
      end
    end
  end

  // Output decode; values are registered below so the line is glitch-free.
  always_comb begin
    w_Serial = 1'b1;
    w_Active = 1'b0;
    w_Done   = 1'b0;
    case (r_State)
      START: begin
        w_Serial = 1'b0;
        w_Active = 1'b1;
      end
      DATA: begin
        w_Serial = r_Shift[r_Bit_Index];
        w_Active = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_Serial = ^r_Shift;
        w_Active = 1'b1;
      end
`endif
      STOP:    w_Active = 1'b1;
      CLEANUP: w_Done   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      r_Tx_Serial <= w_Serial;
      r_Tx_Active <= w_Active;
      r_Tx_Done   <= w_Done;
    end
  end

  assign o_Tx_Ready   = w_Ready;
  assign o_Fifo_Count = r_Count;
  assign o_Tx_Serial  = r_Tx_Serial;
  assign o_Tx_Active  = r_Tx_Active;
  assign o_Tx_Done    = r_Tx_Done;

endmodule
